beep_rate_meter: RTL and testbench
==================================

// Module: beep_rate_meter
// PURPOSE
//  Receive-side partner of the beep-rate clock divider. Samples one toggling beep-rate
//  signal, measures its half-period in clk cycles and classifies it as one of the four
//  beep rates (slower/slow/moderate/fast). Used for built-in self-test of the beeper
//  path and for the board-level loopback check of the tilt-alarm output.
// PARAMETERS
//  CNT_W     27          width of period counter and half_period output
//  HP_SLOWER 25_000_001  nominal half-period, code 1 (divider toggles every N+1 cycles)
//  HP_SLOW   16_666_667  nominal half-period, code 2
//  HP_MOD    12_500_001  nominal half-period, code 3
//  HP_FAST   5_000_001   nominal half-period, code 4
//  TOL       250_000     max |measured - nominal| accepted for a class match
//  TIMEOUT   100_000_000 cycles with no edge before declaring signal lost
//  STABLE_N  2           consecutive same-class measurements required for rate_valid
// PORTS
//  clk          in   1      system clock (50 MHz)
//  rst_n        in   1      asynchronous reset, active low
//  enable       in   1      1 = measure; 0 = idle, outputs cleared
//  beep_in      in   1      toggling beep-rate signal, asynchronous to clk
//  half_period  out  CNT_W  last measured half-period in clk cycles
//  meas_stb     out  1      one-cycle pulse: new half_period/classification available
//  rate_code    out  3      0 = none/unknown, 1..4 = slower/slow/moderate/fast
//  rate_valid   out  1      rate_code confirmed by STABLE_N matching measurements
//  timeout      out  1      high while no edge has been seen for TIMEOUT cycles
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, sync flops 0, counter 0, match count 0, state IDLE.
//  - Input: 2-flop synchronizer, then registered previous value. Edge = sync2 != prev (both edges).
//  - Latency: meas_stb rises on the 3rd rising clk edge after the one that first samples the new beep_in level.
//  - FSM IDLE: enable=0. Outputs held at 0. enable=1 -> ARM.
//  - FSM ARM: waiting for the first edge. The counter counts but is not reported.
//    - First edge: counter <= 1, go to MEAS, no meas_stb.
//  - FSM MEAS: counter increments every cycle and saturates at all-ones.
//    - On edge: half_period <= counter, counter <= 1, meas_stb=1 for one cycle.
//    - half_period = number of clk cycles between consecutive detected edges.
//  - Classification on each edge:
//    - Compute |half_period - HP_x| at CNT_W+1 bits, unsigned.
//    - First class with difference <= TOL wins, checked in order 1..4; otherwise class 0.
//  - Stability counting:
//    - Class equals the previous class and is nonzero: match count increments, saturating at STABLE_N.
//    - Otherwise: match count <= 1 (0 if class 0), rate_valid <= 0, rate_code <= 0.
//    - match count reaches STABLE_N: rate_code <= class, rate_valid <= 1.
//    - Both outputs hold until the next meas_stb, timeout, or enable drop.
//  - Timeout: in ARM or MEAS, counter == TIMEOUT with no edge that cycle:
//    - timeout <= 1; rate_code, rate_valid and match count <= 0; go to ARM.
//    - timeout clears on the next detected edge.
//    - An edge in the same cycle as TIMEOUT wins: it counts as a normal edge and no timeout is raised.
//  - enable=0 in any state: next cycle go to IDLE and clear all outputs.
//    - A meas_stb pending in that cycle is suppressed.
//  - rst_n asserted mid-measurement: immediate clear. The first edge after release only arms.
// TESTING (sim overrides: HP_SLOWER=50 HP_SLOW=34 HP_MOD=26 HP_FAST=11 TOL=2 TIMEOUT=200 STABLE_N=2)
//  1. beep_in toggles every 26 cycles
//     -> stb#1 half_period=26, rate_valid=0; stb#2 rate_code=3, rate_valid=1.
//  2. Toggle every 12 cycles -> code 4 after 2 stbs.
//     Then every 15 cycles -> first stb gives rate_code=0, rate_valid=0, and it stays 0.
//  3. Steady 50-cycle toggling, then beep_in frozen
//     -> timeout=1 exactly 200 cycles after the last edge, rate_code=0.
//     Next edge: timeout=0, no stb. Following edge: stb.
//  4. Rate change 50 -> 34 mid-stream -> first 34 stb drops rate_valid.
//     Second 34 stb gives rate_code=2, rate_valid=1.
//  5. rst_n pulsed low between edges of a 26-cycle stream -> outputs 0 within the same cycle.
//     After release, 3 edges are needed before rate_valid=1.
//  6. 1-cycle-wide glitch on a steady line
//     -> half_period=1 at the glitch, then a long value; both classify 0 and rate_valid stays 0.

Source files
------------

// File: rtl/beep_rate_meter.sv
// beep_rate_meter: measures the half-period of a toggling beep-rate signal in clk
// cycles and classifies it as one of the four beeper rates, with stability and timeout.
module beep_rate_meter #(
  parameter int unsigned CNT_W     = 27,
  parameter int unsigned HP_SLOWER = 25_000_001,
  parameter int unsigned HP_SLOW   = 16_666_667,
  parameter int unsigned HP_MOD    = 12_500_001,
  parameter int unsigned HP_FAST   = 5_000_001,
  parameter int unsigned TOL       = 250_000,
  parameter int unsigned TIMEOUT   = 100_000_000,
  parameter int unsigned STABLE_N  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             beep_in,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_stb,
  output logic [2:0]       rate_code,
  output logic             rate_valid,
  output logic             timeout
);

  localparam int unsigned MC_W = $clog2(STABLE_N + 1);
  localparam logic [CNT_W:0]   HP1   = (CNT_W+1)'(HP_SLOWER);
  localparam logic [CNT_W:0]   HP2   = (CNT_W+1)'(HP_SLOW);
  localparam logic [CNT_W:0]   HP3   = (CNT_W+1)'(HP_MOD);
  localparam logic [CNT_W:0]   HP4   = (CNT_W+1)'(HP_FAST);
  localparam logic [CNT_W:0]   TOL_W = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] TO_W  = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0]  SN_W  = MC_W'(STABLE_N);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t           state;
  logic [1:0]       sync;
  logic             prev;
  logic             edge_q;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] cnt_inc;
  logic [MC_W-1:0]  match_cnt;
  logic [MC_W-1:0]  mc_next;
  logic [2:0]       prev_cls;
  logic [2:0]       cls;
  logic             same_cls;
  logic             hit;

  function automatic logic [CNT_W:0] absdiff(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W:0]   b);
    logic [CNT_W:0] ax;
    ax = {1'b0, a};
    return (ax >= b) ? (ax - b) : (b - ax);
  endfunction

  // Synchronizer and edge detector run regardless of enable so that re-enabling
  // never sees a stale level difference as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      prev   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync   <= {sync[0], beep_in};
      prev   <= sync[1];
      edge_q <= sync[1] ^ prev;
    end
  end

  always_comb begin
    cls = 3'd0;
    if      (absdiff(counter, HP1) <= TOL_W) cls = 3'd1;
    else if (absdiff(counter, HP2) <= TOL_W) cls = 3'd2;
    else if (absdiff(counter, HP3) <= TOL_W) cls = 3'd3;
    else if (absdiff(counter, HP4) <= TOL_W) cls = 3'd4;
  end

  always_comb begin
    cnt_inc  = (&counter) ? counter : counter + CNT_W'(1);
    same_cls = (cls != 3'd0) && (cls == prev_cls);
    mc_next  = '0;
    if (same_cls)
      mc_next = (match_cnt >= SN_W) ? match_cnt : match_cnt + MC_W'(1);
    else if (cls != 3'd0)
      mc_next = MC_W'(1);
    hit = (cls != 3'd0) && (mc_next == SN_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter     <= '0;
      half_period <= '0;
      meas_stb    <= 1'b0;
      rate_code   <= 3'd0;
      rate_valid  <= 1'b0;
      timeout     <= 1'b0;
      match_cnt   <= '0;
      prev_cls    <= 3'd0;
    end else begin
      meas_stb <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        counter     <= '0;
        half_period <= '0;
        rate_code   <= 3'd0;
        rate_valid  <= 1'b0;
        timeout     <= 1'b0;
        match_cnt   <= '0;
        prev_cls    <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            state   <= ARM;
            counter <= '0;
          end
          ARM: begin
            if (edge_q) begin
              counter <= CNT_W'(1);
              timeout <= 1'b0;
              state   <= MEAS;
            end else begin
              counter <= cnt_inc;
              if (counter == TO_W) begin
                timeout    <= 1'b1;
                rate_code  <= 3'd0;
                rate_valid <= 1'b0;
                match_cnt  <= '0;
                prev_cls   <= 3'd0;
              end
            end
          end
          MEAS: begin
            // An edge coinciding with the timeout count is a normal measurement.
            if (edge_q) begin
              half_period <= counter;
              counter     <= CNT_W'(1);
              meas_stb    <= 1'b1;
              timeout     <= 1'b0;
              prev_cls    <= cls;
              match_cnt   <= mc_next;
              if (hit) begin
                rate_code  <= cls;
                rate_valid <= 1'b1;
              end else if (!same_cls) begin
                rate_code  <= 3'd0;
                rate_valid <= 1'b0;
              end
            end else if (counter == TO_W) begin
              timeout    <= 1'b1;
              rate_code  <= 3'd0;
              rate_valid <= 1'b0;
              match_cnt  <= '0;
              prev_cls   <= 3'd0;
              counter    <= cnt_inc;
              state      <= ARM;
            end else begin
              counter <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beep_rate_meter.sv
// tb_beep_rate_meter: random and directed beep streams, scoreboard of expected
// measurements built from inter-toggle intervals, plus timing/reset/timeout checks.
module tb_beep_rate_meter;
  localparam int CNT_W     = 27;
  localparam int HP_SLOWER = 50;
  localparam int HP_SLOW   = 34;
  localparam int HP_MOD    = 26;
  localparam int HP_FAST   = 11;
  localparam int TOL       = 2;
  localparam int TIMEOUT   = 200;
  localparam int STABLE_N  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             beep_in = 1'b0;
  logic [CNT_W-1:0] half_period;
  logic             meas_stb;
  logic [2:0]       rate_code;
  logic             rate_valid;
  logic             timeout;

  beep_rate_meter #(
    .CNT_W(CNT_W), .HP_SLOWER(HP_SLOWER), .HP_SLOW(HP_SLOW), .HP_MOD(HP_MOD),
    .HP_FAST(HP_FAST), .TOL(TOL), .TIMEOUT(TIMEOUT), .STABLE_N(STABLE_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .beep_in(beep_in),
    .half_period(half_period), .meas_stb(meas_stb), .rate_code(rate_code),
    .rate_valid(rate_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int hp; int code; int valid; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_flip = 0;
  int nom[4] = '{HP_SLOWER, HP_SLOW, HP_MOD, HP_FAST};

  // Reference model state: session armed, last class, run length, reported rate.
  int armed = 0, m_prev = 0, m_run = 0, m_code = 0, m_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int classify(int hp);
    for (int i = 0; i < 4; i++)
      if (((hp > nom[i]) ? hp - nom[i] : nom[i] - hp) <= TOL) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    armed = 0; m_prev = 0; m_run = 0; m_code = 0; m_valid = 0;
  endtask

  task automatic model_edge(int iv);
    exp_t e;
    int c;
    if (armed != 0 && iv > TIMEOUT) model_reset();
    if (armed == 0) begin
      armed = 1;
      return;
    end
    c = classify(iv);
    if (c != 0 && c == m_prev) m_run = m_run + 1;
    else m_run = (c != 0) ? 1 : 0;
    if (c != 0 && m_run >= STABLE_N) begin
      m_code = c; m_valid = 1;
    end else if (m_run <= 1) begin
      m_code = 0; m_valid = 0;
    end
    m_prev = c;
    e.hp = iv; e.code = m_code; e.valid = m_valid;
    sbq.push_back(e);
  endtask

  task automatic flip_after(int n);
    repeat (n) @(negedge clk);
    beep_in = ~beep_in;
    model_edge(cyc - last_flip);
    last_flip = cyc;
  endtask

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(string name);
    chk({name, "_hp"}, int'(half_period), 0);
    chk({name, "_stb"}, int'(meas_stb), 0);
    chk({name, "_code"}, int'(rate_code), 0);
    chk({name, "_valid"}, int'(rate_valid), 0);
    chk({name, "_to"}, int'(timeout), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && meas_stb) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL stb_unexpected: got hp=%0d code=%0d valid=%0d expected no strobe",
                 half_period, rate_code, rate_valid);
      end else begin
        mon_e = sbq.pop_front();
        if (int'(half_period) != mon_e.hp || int'(rate_code) != mon_e.code ||
            int'(rate_valid) != mon_e.valid) begin
          n_err++;
          $display("FAIL stb_meas: got hp=%0d code=%0d valid=%0d expected hp=%0d code=%0d valid=%0d",
                   half_period, rate_code, rate_valid, mon_e.hp, mon_e.code, mon_e.valid);
        end
      end
    end
  end

  initial begin
    int r, len, iv;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1; enable = 1'b1;
    model_reset();
    last_flip = cyc;
    repeat (4) @(negedge clk);

    // 26-cycle stream with strobe latency check on the first measurement
    flip_after(2);
    flip_after(26);
    repeat (3) @(negedge clk);
    chk("latency_pre", int'(meas_stb), 0);
    @(negedge clk);
    chk("latency_stb", int'(meas_stb), 1);
    flip_after(22);

    // 12 -> code 4, then 15 -> code 0
    repeat (3) flip_after(12);
    repeat (3) flip_after(15);

    // steady 50 then frozen: timeout exactly 200 cycles after the last strobe
    repeat (4) flip_after(50);
    repeat (203) @(negedge clk);
    chk("timeout_early", int'(timeout), 0);
    @(negedge clk);
    chk("timeout_set", int'(timeout), 1);
    chk("timeout_code", int'(rate_code), 0);
    chk("timeout_valid", int'(rate_valid), 0);
    flip_after(10);
    repeat (4) @(negedge clk);
    chk("timeout_clear", int'(timeout), 0);
    flip_after(46);

    // interval equal to TIMEOUT measures normally; one more cycle times out
    flip_after(50);
    flip_after(200);
    repeat (4) @(negedge clk);
    chk("to_boundary", int'(timeout), 0);
    flip_after(197);
    flip_after(20);

    // rate change 50 -> 34
    repeat (3) flip_after(50);
    repeat (2) flip_after(34);

    // async reset mid-measurement on a 26 stream
    repeat (3) flip_after(26);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    last_flip = cyc;
    if (beep_in) model_edge(0);
    repeat (3) flip_after(26);

    // glitch on a steady line
    flip_after(30);
    flip_after(1);
    flip_after(60);

    // enable drop suppresses a pending strobe and clears outputs
    repeat (3) flip_after(26);
    repeat (26) @(negedge clk);
    beep_in = ~beep_in;
    last_flip = cyc;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk_zero("disable");
    model_reset();
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    flip_after(5);
    repeat (2) flip_after(26);

    // randomized bursts near nominal rates plus arbitrary intervals
    for (int b = 0; b < 40; b++) begin
      r = int'($urandom_range(0, 4));
      len = int'($urandom_range(1, 5));
      for (int j = 0; j < len; j++) begin
        if (r < 4) iv = nom[r] + int'($urandom_range(0, 8)) - 4;
        else iv = int'($urandom_range(1, 190));
        flip_after(iv);
      end
    end

    repeat (10) @(negedge clk);
    chk("sbq_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
